// File: rtl/rc4_pkg.sv
// -----------------------------------------------------------------------------
// rc4_pkg
// Shared definitions for the RC4 message decryptor:
//   - MSG_LEN_DEFAULT : default number of ciphertext bytes per run
//   - ASCII_* bounds  : accepted plaintext alphabet (space, 'a'..'z')
//   - state_e         : decryptor sequencer states
// -----------------------------------------------------------------------------
package rc4_pkg;

  localparam int MSG_LEN_DEFAULT = 32;

  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;
  localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;

  // One byte of keystream takes the thirteen states ST_ADDR_I..ST_NEXT,
  // one cycle each. ST_DONE holds until the requester drops start.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_I,
    ST_WAIT_I,
    ST_READ_I,
    ST_ADDR_J,
    ST_WAIT_J,
    ST_READ_J,
    ST_WR_I,
    ST_WR_J,
    ST_ADDR_F,
    ST_WAIT_F,
    ST_READ_F,
    ST_WR_DEC,
    ST_NEXT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/decrypt_message_ascii_checker.sv
// -----------------------------------------------------------------------------
// ascii_checker
// Combinational plaintext filter: is_valid is high when byte_in is a space
// (0x20) or a lowercase letter (0x61..0x7A).
// Ports:
//   byte_in  [7:0] in  : candidate plaintext byte
//   is_valid       out : byte belongs to the accepted alphabet
// Only compiled when DECRYPT_ASCII_CHECK_EN is defined; the default build of
// decrypt_message does not use it.
// -----------------------------------------------------------------------------
`ifdef DECRYPT_ASCII_CHECK_EN
module ascii_checker
  import rc4_pkg::*;
(
  input  logic [7:0] byte_in,
  output logic       is_valid
);

  always_comb begin
    is_valid = (byte_in == ASCII_SPACE) ||
               ((byte_in >= ASCII_LOWER_A) && (byte_in <= ASCII_LOWER_Z));
  end

endmodule
`endif

// File: rtl/decrypt_message.sv
// -----------------------------------------------------------------------------
// decrypt_message
// RC4 PRGA stage: walks an already-shuffled S-box held in external memory,
// generates one keystream byte per ciphertext byte, and writes the XOR of the
// two into a plaintext RAM. Each byte takes 13 cycles; decrypt_finish rises
// 13*MSG_LEN+1 cycles after the edge that accepts start.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start                    : run request, sampled in IDLE; held high it keeps
//                              DONE (and decrypt_finish) asserted
//   s_data_in  [7:0]  in     : S-memory read data (one cycle after address)
//   s_address  [7:0]  out    : S-memory address
//   s_data_out [7:0]  out    : S-memory write data
//   s_is_write        out    : S-memory write enable
//   rom_address[AW-1:0] out  : ciphertext ROM address (= k outside IDLE)
//   rom_data   [7:0]  in     : ciphertext ROM data (one cycle after address)
//   dec_address[AW-1:0] out  : plaintext RAM address
//   dec_data   [7:0]  out    : plaintext RAM data
//   dec_is_write      out    : plaintext RAM write enable
//   decrypt_finish    out    : run complete
//   key_invalid       out    : plaintext rejected (optional feature)
//
// Optional feature: define DECRYPT_ASCII_CHECK_EN to reject any plaintext byte
// outside {0x20, 0x61..0x7A}. The offending byte is not written, key_invalid
// is set and the run ends early. key_invalid holds until the next accepted
// start. Without the macro key_invalid is constant 0.
//
// All outputs are registered. Their next value is derived from the next state
// so that, e.g., s_address already shows i in the cycle the FSM is in ADDR_I.
// -----------------------------------------------------------------------------
module decrypt_message
  import rc4_pkg::*;
#(
  parameter  int MSG_LEN = MSG_LEN_DEFAULT,
  localparam int AW      = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    s_data_in,
  output logic [7:0]    s_address,
  output logic [7:0]    s_data_out,
  output logic          s_is_write,
  output logic [AW-1:0] rom_address,
  input  logic [7:0]    rom_data,
  output logic [AW-1:0] dec_address,
  output logic [7:0]    dec_data,
  output logic          dec_is_write,
  output logic          decrypt_finish,
  output logic          key_invalid
);

  localparam logic [AW-1:0] K_LAST = AW'(MSG_LEN - 1);

  // Algorithm state
  state_e        state_q, state_d;
  logic [7:0]    i_q, i_d;
  logic [7:0]    j_q, j_d;
  logic [AW-1:0] k_q, k_d;
  logic [7:0]    si_q, si_d;
  logic [7:0]    sj_q, sj_d;
  logic [7:0]    f_q, f_d;

  // Registered outputs
  logic [7:0]    s_address_q, s_address_d;
  logic [7:0]    s_data_out_q, s_data_out_d;
  logic          s_is_write_q, s_is_write_d;
  logic [AW-1:0] rom_address_q, rom_address_d;
  logic [AW-1:0] dec_address_q, dec_address_d;
  logic [7:0]    dec_data_q, dec_data_d;
  logic          dec_is_write_q, dec_is_write_d;
  logic          decrypt_finish_q, decrypt_finish_d;

  // Plaintext byte presented in WR_DEC. Only meaningful when entering WR_DEC
  // from READ_F, where f_d is the freshly read keystream byte and rom_data
  // has long been stable for address k.
  logic [7:0]    plain_d;
  assign plain_d = f_d ^ rom_data;

`ifdef DECRYPT_ASCII_CHECK_EN
  logic key_invalid_q, key_invalid_d;
  logic bad_q, bad_d;       // plaintext byte held in WR_DEC was rejected
  logic plain_ok;

  ascii_checker u_ascii_checker (
    .byte_in  (plain_d),
    .is_valid (plain_ok)
  );
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    si_d    = si_q;
    sj_d    = sj_q;
    f_d     = f_q;
`ifdef DECRYPT_ASCII_CHECK_EN
    key_invalid_d = key_invalid_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          i_d     = 8'd1;
          j_d     = 8'd0;
          k_d     = '0;
          state_d = ST_ADDR_I;
`ifdef DECRYPT_ASCII_CHECK_EN
          key_invalid_d = 1'b0;
`endif
        end
      end
      ST_ADDR_I: state_d = ST_WAIT_I;
      ST_WAIT_I: state_d = ST_READ_I;
      ST_READ_I: begin
        si_d    = s_data_in;
        j_d     = j_q + s_data_in;
        state_d = ST_ADDR_J;
      end
      ST_ADDR_J: state_d = ST_WAIT_J;
      ST_WAIT_J: state_d = ST_READ_J;
      ST_READ_J: begin
        sj_d    = s_data_in;
        state_d = ST_WR_I;
      end
      // When i == j both writes carry S[i], so the swap is a no-op.
      ST_WR_I:   state_d = ST_WR_J;
      ST_WR_J:   state_d = ST_ADDR_F;
      ST_ADDR_F: state_d = ST_WAIT_F;
      ST_WAIT_F: state_d = ST_READ_F;
      ST_READ_F: begin
        f_d     = s_data_in;
        state_d = ST_WR_DEC;
      end
      ST_WR_DEC: begin
        state_d = ST_NEXT;
`ifdef DECRYPT_ASCII_CHECK_EN
        if (bad_q) begin
          key_invalid_d = 1'b1;
          state_d       = ST_DONE;
        end
`endif
      end
      ST_NEXT: begin
        if (k_q == K_LAST) begin
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + AW'(1);
          i_d     = i_q + 8'd1;
          state_d = ST_ADDR_I;
        end
      end
      // Leave only after decrypt_finish has been seen high for a cycle, so a
      // requester that already dropped start still gets a finish pulse.
      ST_DONE: begin
        if (decrypt_finish_q && !start) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: values for the state being entered
  // ---------------------------------------------------------------------------
  always_comb begin
    s_address_d    = 8'd0;
    s_data_out_d   = 8'd0;
    s_is_write_d   = 1'b0;
    rom_address_d  = '0;
    dec_address_d  = '0;
    dec_data_d     = 8'd0;
    dec_is_write_d = 1'b0;
`ifdef DECRYPT_ASCII_CHECK_EN
    bad_d = 1'b0;
`endif

    if (state_d != ST_IDLE) begin
      rom_address_d = k_d;
    end

    // Read addresses are held through the WAIT/READ states so the
    // registered S-memory keeps returning the same word.
    unique case (state_d)
      ST_ADDR_I, ST_WAIT_I, ST_READ_I: s_address_d = i_d;
      ST_ADDR_J, ST_WAIT_J, ST_READ_J: s_address_d = j_d;
      ST_WR_I: begin
        s_address_d  = i_d;
        s_data_out_d = sj_d;
        s_is_write_d = 1'b1;
      end
      ST_WR_J: begin
        s_address_d  = j_d;
        s_data_out_d = si_d;
        s_is_write_d = 1'b1;
      end
      ST_ADDR_F, ST_WAIT_F, ST_READ_F: s_address_d = si_d + sj_d;
      ST_WR_DEC: begin
        dec_address_d  = k_d;
        dec_data_d     = plain_d;
`ifdef DECRYPT_ASCII_CHECK_EN
        dec_is_write_d = plain_ok;
        bad_d          = !plain_ok;
`else
        dec_is_write_d = 1'b1;
`endif
      end
      default: ;
    endcase

    // Finish follows the first DONE cycle, which sets the overall latency to
    // 13*MSG_LEN+1, and drops together with the return to IDLE.
    decrypt_finish_d = (state_q == ST_DONE) && (state_d == ST_DONE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      i_q              <= 8'd0;
      j_q              <= 8'd0;
      k_q              <= '0;
      si_q             <= 8'd0;
      sj_q             <= 8'd0;
      f_q              <= 8'd0;
      s_address_q      <= 8'd0;
      s_data_out_q     <= 8'd0;
      s_is_write_q     <= 1'b0;
      rom_address_q    <= '0;
      dec_address_q    <= '0;
      dec_data_q       <= 8'd0;
      dec_is_write_q   <= 1'b0;
      decrypt_finish_q <= 1'b0;
`ifdef DECRYPT_ASCII_CHECK_EN
      key_invalid_q    <= 1'b0;
      bad_q            <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      i_q              <= i_d;
      j_q              <= j_d;
      k_q              <= k_d;
      si_q             <= si_d;
      sj_q             <= sj_d;
      f_q              <= f_d;
      s_address_q      <= s_address_d;
      s_data_out_q     <= s_data_out_d;
      s_is_write_q     <= s_is_write_d;
      rom_address_q    <= rom_address_d;
      dec_address_q    <= dec_address_d;
      dec_data_q       <= dec_data_d;
      dec_is_write_q   <= dec_is_write_d;
      decrypt_finish_q <= decrypt_finish_d;
`ifdef DECRYPT_ASCII_CHECK_EN
      key_invalid_q    <= key_invalid_d;
      bad_q            <= bad_d;
`endif
    end
  end

  assign s_address      = s_address_q;
  assign s_data_out     = s_data_out_q;
  assign s_is_write     = s_is_write_q;
  assign rom_address    = rom_address_q;
  assign dec_address    = dec_address_q;
  assign dec_data       = dec_data_q;
  assign dec_is_write   = dec_is_write_q;
  assign decrypt_finish = decrypt_finish_q;
`ifdef DECRYPT_ASCII_CHECK_EN
  assign key_invalid    = key_invalid_q;
`else
  assign key_invalid    = 1'b0;
`endif

endmodule

// File: tb/tb_decrypt_message.sv
// -----------------------------------------------------------------------------
// tb_decrypt_message
// Directed bench for decrypt_message (MSG_LEN = 32). Models a registered-read
// S-memory and ciphertext ROM, logs every S and plaintext write, and checks
// reset, the first two hand-computed bytes, a full run (latency, write counts,
// plaintext), DONE/start handshake, mid-run reset, the i==j swap and (with
// DECRYPT_ASCII_CHECK_EN) the plaintext rejection path.
// -----------------------------------------------------------------------------
module tb_decrypt_message;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] s_data_in;
  logic [7:0] s_address;
  logic [7:0] s_data_out;
  logic       s_is_write;
  logic [4:0] rom_address;
  logic [7:0] rom_data;
  logic [4:0] dec_address;
  logic [7:0] dec_data;
  logic       dec_is_write;
  logic       decrypt_finish;
  logic       key_invalid;

  always #5 clk = ~clk;

  decrypt_message dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .s_data_in      (s_data_in),
    .s_address      (s_address),
    .s_data_out     (s_data_out),
    .s_is_write     (s_is_write),
    .rom_address    (rom_address),
    .rom_data       (rom_data),
    .dec_address    (dec_address),
    .dec_data       (dec_data),
    .dec_is_write   (dec_is_write),
    .decrypt_finish (decrypt_finish),
    .key_invalid    (key_invalid)
  );

  // S-memory: registered read, preload to identity plus one optional override
  logic [7:0] s_mem [256];
  logic       preload_req = 1'b0;
  logic       ov_en = 1'b0;
  logic [7:0] ov_addr = 8'd0;
  logic [7:0] ov_data = 8'd0;

  always @(posedge clk) begin
    if (preload_req) begin
      for (int a = 0; a < 256; a++) s_mem[a] <= 8'(a);
      if (ov_en) s_mem[ov_addr] <= ov_data;
    end else if (s_is_write) begin
      s_mem[s_address] <= s_data_out;
    end
    s_data_in <= s_mem[s_address];
  end

  // Ciphertext ROM, written only by the stimulus
  logic [7:0] rom_mem [32];
  always @(posedge clk) rom_data <= rom_mem[rom_address];

  // Write monitors
  int         cyc = 0;
  int         s_wr_cnt = 0;
  int         dec_wr_cnt = 0;
  logic [7:0] sw_a [1024];
  logic [7:0] sw_d [1024];
  logic [4:0] dw_a [1024];
  logic [7:0] dw_d [1024];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (s_is_write) begin
      sw_a[s_wr_cnt & 1023] <= s_address;
      sw_d[s_wr_cnt & 1023] <= s_data_out;
      s_wr_cnt <= s_wr_cnt + 1;
    end
    if (dec_is_write) begin
      dw_a[dec_wr_cnt & 1023] <= dec_address;
      dw_d[dec_wr_cnt & 1023] <= dec_data;
      dec_wr_cnt <= dec_wr_cnt + 1;
    end
  end

  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] ks_exp [32];

  function automatic logic [7:0] pt_byte(int k);
    return 8'(8'h61 + (k % 26));
  endfunction

  // Reference RC4 PRGA on an identity S-box
  task automatic build_ks();
    logic [7:0] s [256];
    logic [7:0] i, j, t;
    for (int a = 0; a < 256; a++) s[a] = 8'(a);
    i = 8'd0;
    j = 8'd0;
    for (int k = 0; k < 32; k++) begin
      i = i + 8'd1;
      j = j + s[i];
      t = s[i];
      s[i] = s[j];
      s[j] = t;
      ks_exp[k] = s[8'(s[i] + s[j])];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic en, input logic [7:0] a, input logic [7:0] d);
    ov_en = en;
    ov_addr = a;
    ov_data = d;
    preload_req = 1'b1;
    tick();
    preload_req = 1'b0;
  endtask

  // Waits (bounded) for decrypt_finish; returns cycles waited
  task automatic wait_finish(input int budget, output int lat);
    lat = 0;
    while (decrypt_finish !== 1'b1 && lat < budget) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish_and_release(input string name);
    int lat;
    wait_finish(1000, lat);
    n_checks++;
    if (decrypt_finish !== 1'b1) $display("FAIL %s_finish: decrypt_finish=%b expected 1", name, decrypt_finish);
    else n_pass++;
    start = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({s_address, s_data_out, s_is_write, rom_address, dec_address, dec_data,
         dec_is_write, decrypt_finish, key_invalid} !== '0)
      $display("FAIL reset_outputs: s_addr=%h s_wr=%b rom=%h dec_wr=%b fin=%b kinv=%b expected all 0",
               s_address, s_is_write, rom_address, dec_is_write, decrypt_finish, key_invalid);
    else n_pass++;
    rst = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_two_bytes();
    int s0, d0, n;
    rom_mem[0] = 8'h63;
    rom_mem[1] = 8'h64;
    preload(1'b0, 8'd0, 8'd0);
    s0 = s_wr_cnt;
    d0 = dec_wr_cnt;
    start = 1'b1;
    tick();
    n = 0;
    while (s_wr_cnt < s0 + 4 && n < 200) begin tick(); n++; end
    n_checks++;
    if (sw_a[(s0+2)&1023] !== 8'h02 || sw_d[(s0+2)&1023] !== 8'h03 ||
        sw_a[(s0+3)&1023] !== 8'h03 || sw_d[(s0+3)&1023] !== 8'h02)
      $display("FAIL byte1_swap_writes: (%h<-%h),(%h<-%h) expected (02<-03),(03<-02)",
               sw_a[(s0+2)&1023], sw_d[(s0+2)&1023], sw_a[(s0+3)&1023], sw_d[(s0+3)&1023]);
    else n_pass++;
    n = 0;
    while (dec_wr_cnt < d0 + 2 && n < 200) begin tick(); n++; end
    n_checks++;
    if (s_mem[2] !== 8'h03 || s_mem[3] !== 8'h02)
      $display("FAIL byte1_sbox: S[2]=%h S[3]=%h expected 03 02", s_mem[2], s_mem[3]);
    else n_pass++;
    n_checks++;
    if (dw_a[d0&1023] !== 5'd0 || dw_d[d0&1023] !== 8'h61)
      $display("FAIL dec_byte0: addr=%h data=%h expected 00 61", dw_a[d0&1023], dw_d[d0&1023]);
    else n_pass++;
    n_checks++;
    if (dw_a[(d0+1)&1023] !== 5'd1 || dw_d[(d0+1)&1023] !== 8'h61)
      $display("FAIL dec_byte1: addr=%h data=%h expected 01 61", dw_a[(d0+1)&1023], dw_d[(d0+1)&1023]);
    else n_pass++;
    finish_and_release("two_bytes");
    $display("test_two_bytes done: dec0=%h dec1=%h", dw_d[d0&1023], dw_d[(d0+1)&1023]);
  endtask

  // Leaves the DUT in DONE with start held high
  task automatic test_full_run();
    int s0, d0, lat;
    for (int k = 0; k < 32; k++) rom_mem[k] = ks_exp[k] ^ pt_byte(k);
    preload(1'b0, 8'd0, 8'd0);
    s0 = s_wr_cnt;
    d0 = dec_wr_cnt;
    start = 1'b1;
    tick();
    wait_finish(1000, lat);
    n_checks++;
    if (lat !== 417) $display("FAIL full_latency: got %0d cycles expected 417", lat);
    else n_pass++;
    n_checks++;
    if (s_wr_cnt - s0 !== 64) $display("FAIL full_s_writes: got %0d expected 64", s_wr_cnt - s0);
    else n_pass++;
    n_checks++;
    if (dec_wr_cnt - d0 !== 32) $display("FAIL full_dec_writes: got %0d expected 32", dec_wr_cnt - d0);
    else n_pass++;
    for (int k = 0; k < 32; k++) begin
      n_checks++;
      if (dw_a[(d0+k)&1023] !== 5'(k) || dw_d[(d0+k)&1023] !== pt_byte(k))
        $display("FAIL full_plain[%0d]: addr=%h data=%h expected %h %h", k,
                 dw_a[(d0+k)&1023], dw_d[(d0+k)&1023], 5'(k), pt_byte(k));
      else n_pass++;
    end
    $display("test_full_run done: latency=%0d s_writes=%0d dec_writes=%0d", lat, s_wr_cnt - s0, dec_wr_cnt - d0);
  endtask

  task automatic test_hold_start();
    int s0, d0;
    s0 = s_wr_cnt;
    d0 = dec_wr_cnt;
    for (int n = 0; n < 4; n++) begin
      tick();
      n_checks++;
      if (decrypt_finish !== 1'b1) $display("FAIL hold_finish[%0d]: got %b expected 1", n, decrypt_finish);
      else n_pass++;
    end
    start = 1'b0;
    tick();
    n_checks++;
    if (decrypt_finish !== 1'b0) $display("FAIL release_finish: got %b expected 0", decrypt_finish);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if (s_wr_cnt !== s0 || dec_wr_cnt !== d0 || rom_address !== 5'd0)
      $display("FAIL release_quiet: s_writes=%0d dec_writes=%0d rom=%h expected 0 0 00",
               s_wr_cnt - s0, dec_wr_cnt - d0, rom_address);
    else n_pass++;
    $display("test_hold_start done");
  endtask

  task automatic test_reset_mid_run();
    int d0, n;
    preload(1'b0, 8'd0, 8'd0);
    start = 1'b1;
    tick();
    for (int m = 0; m < 136; m++) tick();
    n_checks++;
    if (s_is_write !== 1'b1 || s_address !== 8'd11)
      $display("FAIL midrun_wr_i: s_wr=%b s_addr=%h expected 1 0b", s_is_write, s_address);
    else n_pass++;
    rst = 1'b1;
    start = 1'b0;
    tick();
    n_checks++;
    if ({s_address, s_data_out, s_is_write, rom_address, dec_address, dec_data,
         dec_is_write, decrypt_finish, key_invalid} !== '0)
      $display("FAIL midrun_reset_outputs: s_addr=%h s_wr=%b rom=%h dec_wr=%b fin=%b expected all 0",
               s_address, s_is_write, rom_address, dec_is_write, decrypt_finish);
    else n_pass++;
    rst = 1'b0;
    preload(1'b0, 8'd0, 8'd0);
    d0 = dec_wr_cnt;
    start = 1'b1;
    tick();
    n_checks++;
    if (s_address !== 8'd1 || rom_address !== 5'd0)
      $display("FAIL restart_addr_i: s_addr=%h rom=%h expected 01 00", s_address, rom_address);
    else n_pass++;
    tick(); tick(); tick();
    n_checks++;
    if (s_address !== 8'd1) $display("FAIL restart_addr_j: s_addr=%h expected 01", s_address);
    else n_pass++;
    n = 0;
    while (dec_wr_cnt < d0 + 1 && n < 100) begin tick(); n++; end
    n_checks++;
    if (dw_a[d0&1023] !== 5'd0 || dw_d[d0&1023] !== 8'h61)
      $display("FAIL restart_dec0: addr=%h data=%h expected 00 61", dw_a[d0&1023], dw_d[d0&1023]);
    else n_pass++;
    finish_and_release("restart");
    $display("test_reset_mid_run done");
  endtask

  task automatic test_i_eq_j();
    int s0, d0, n;
    logic [7:0] save0;
    save0 = rom_mem[0];
    rom_mem[0] = 8'h16;            // f = S[2] = 0x77 -> plaintext 0x61
    preload(1'b1, 8'h02, 8'h77);
    s0 = s_wr_cnt;
    d0 = dec_wr_cnt;
    start = 1'b1;
    tick();
    n = 0;
    while (dec_wr_cnt < d0 + 1 && n < 100) begin tick(); n++; end
    n_checks++;
    if (sw_a[s0&1023] !== 8'h01 || sw_d[s0&1023] !== 8'h01 ||
        sw_a[(s0+1)&1023] !== 8'h01 || sw_d[(s0+1)&1023] !== 8'h01)
      $display("FAIL ieqj_writes: (%h<-%h),(%h<-%h) expected (01<-01),(01<-01)",
               sw_a[s0&1023], sw_d[s0&1023], sw_a[(s0+1)&1023], sw_d[(s0+1)&1023]);
    else n_pass++;
    n_checks++;
    if (s_mem[1] !== 8'h01 || dw_d[d0&1023] !== 8'h61)
      $display("FAIL ieqj_result: S[1]=%h dec0=%h expected 01 61", s_mem[1], dw_d[d0&1023]);
    else n_pass++;
    finish_and_release("ieqj");
    rom_mem[0] = save0;
    $display("test_i_eq_j done");
  endtask

`ifdef DECRYPT_ASCII_CHECK_EN
  task automatic test_key_invalid();
    int d0, lat;
    logic [7:0] save0;
    save0 = rom_mem[0];
    rom_mem[0] = 8'h00;            // plaintext 0x02 -> rejected
    preload(1'b0, 8'd0, 8'd0);
    d0 = dec_wr_cnt;
    start = 1'b1;
    tick();
    wait_finish(1000, lat);
    n_checks++;
    if (decrypt_finish !== 1'b1 || key_invalid !== 1'b1)
      $display("FAIL keyinv_flags: fin=%b kinv=%b expected 1 1", decrypt_finish, key_invalid);
    else n_pass++;
    n_checks++;
    if (dec_wr_cnt !== d0) $display("FAIL keyinv_writes: got %0d expected 0", dec_wr_cnt - d0);
    else n_pass++;
    start = 1'b0;
    tick();
    tick();
    n_checks++;
    if (key_invalid !== 1'b1) $display("FAIL keyinv_hold: got %b expected 1", key_invalid);
    else n_pass++;
    rom_mem[0] = save0;
    $display("test_key_invalid done");
  endtask
`endif

  initial begin
    rst = 1'b1;
    start = 1'b0;
    build_ks();
    for (int k = 0; k < 32; k++) rom_mem[k] = ks_exp[k] ^ pt_byte(k);
    test_reset();
    test_two_bytes();
    test_full_run();
    test_hold_start();
    test_reset_mid_run();
    test_i_eq_j();
`ifdef DECRYPT_ASCII_CHECK_EN
    test_key_invalid();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
